// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM states, CLAIM layout.
// Pure definitions; no logic, no latency.
package irq_ctrl_pkg;

   localparam logic [2:0] IC_CTRL     = 3'd0;
   localparam logic [2:0] IC_MASK     = 3'd1;
   localparam logic [2:0] IC_MODE     = 3'd2;
   localparam logic [2:0] IC_PEND     = 3'd3;
   localparam logic [2:0] IC_CLAIM    = 3'd4;
   localparam logic [2:0] IC_COMPLETE = 3'd5;

   localparam int CLAIM_BUSY_BIT = 31;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_SVC = 1'b1
   } ic_state_t;

endpackage

// File: rtl/irq_ctrl_prio.sv
// Fixed-priority encoder, index 0 highest; returns {vld, id} of the lowest set bit.
// Purely combinational, zero latency, no flow control.
module irq_ctrl_prio #(
   parameter int N = 3
) (
   input  logic [N-1:0] vec,
   output logic         vld,
   output logic [2:0]   id
);

   always_comb begin
      vld = 1'b0;
      id  = 3'd0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            vld = 1'b1;
            id  = 3'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks sources, fixed-priority select, claim/complete handshake.
// Source to PEND one edge (plus two when synchronized), PEND to IRQ one more edge; no backpressure.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int N_SRC    = 3,
   parameter int SYNC_EXT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic [31:2]      Addr,
   input  logic             WE,
   input  logic [31:0]      Din,
   output logic [31:0]      Dout,
   output logic             IRQ
);

   logic             ge;
   logic [N_SRC-1:0] mask, mode, pend, hist;
   logic [N_SRC-1:0] src_s, rise, w1c, mode_rise, claim_clr, pend_nxt;
   ic_state_t        state;
   logic [2:0]       svc_id, win_id, off;
   logic             win_vld, claim_acc, wr_complete;
   logic             unused_bits;

   assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

   // The external pin is asynchronous to clk; the other sources are already in this domain.
   generate
      if (SYNC_EXT != 0) begin : g_sync
         logic [1:0] sff;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) sff <= 2'b00;
            else        sff <= {sff[0], irq_src[N_SRC-1]};
         end
         always_comb begin
            src_s            = irq_src;
            src_s[N_SRC-1]   = sff[1];
         end
      end else begin : g_nosync
         assign src_s = irq_src;
      end
   endgenerate

   irq_ctrl_prio #(.N(N_SRC)) u_prio (
      .vec (pend & mask),
      .vld (win_vld),
      .id  (win_id)
   );

   assign off         = Addr[4:2];
   assign wr_complete = WE && (off == IC_COMPLETE);
   assign claim_acc   = WE && (off == IC_CLAIM) && (state == IDLE) && ge && win_vld;
   assign claim_clr   = claim_acc ? (N_SRC'(1) << win_id) : '0;
   assign w1c         = (WE && (off == IC_PEND)) ? Din[N_SRC-1:0] : '0;
   assign mode_rise   = (WE && (off == IC_MODE)) ? (Din[N_SRC-1:0] & ~mode) : '0;
   assign rise        = src_s & ~hist;

   // Edge bits: a fresh edge beats any clear in the same cycle. Level bits follow the input.
   assign pend_nxt = ((mode & (rise | (pend & ~(w1c | claim_clr)))) | (~mode & src_s))
                     & ~mode_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ge     <= 1'b0;
         mask   <= '0;
         mode   <= '0;
         pend   <= '0;
         hist   <= '0;
         state  <= IDLE;
         svc_id <= 3'd0;
         IRQ    <= 1'b0;
      end else begin
         hist <= src_s;
         pend <= pend_nxt;
         if (WE && (off == IC_CTRL)) ge   <= Din[0];
         if (WE && (off == IC_MASK)) mask <= Din[N_SRC-1:0];
         if (WE && (off == IC_MODE)) mode <= Din[N_SRC-1:0];
         case (state)
            IDLE: begin
               if (claim_acc) begin
                  state  <= IN_SVC;
                  svc_id <= win_id;
                  IRQ    <= 1'b0;
               end else begin
                  IRQ <= ge & win_vld;
               end
            end
            IN_SVC: begin
               IRQ <= 1'b0;
               if (wr_complete) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      Dout = '0;
      case (off)
         IC_CTRL: Dout[0]         = ge;
         IC_MASK: Dout[N_SRC-1:0] = mask;
         IC_MODE: Dout[N_SRC-1:0] = mode;
         IC_PEND: Dout[N_SRC-1:0] = pend;
         IC_CLAIM: begin
            Dout[CLAIM_BUSY_BIT] = (state == IN_SVC);
            Dout[2:0]            = (state == IN_SVC) ? svc_id : win_id;
         end
         default: Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expectations, a monitor pops and compares them.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  irq_src = 3'b000;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;

   irq_ctrl #(.N_SRC(3), .SYNC_EXT(1)) dut (
      .clk     (clk),
      .reset   (reset),
      .irq_src (irq_src),
      .Addr    (Addr),
      .WE      (WE),
      .Din     (Din),
      .Dout    (Dout),
      .IRQ     (IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_irq;
      logic [31:0] val;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [31:0] act;
   int          checks = 0;
   int          failures = 0;
   event        chk_ev;

   // Monitor: drains the scoreboard on each falling edge or on an immediate-sample request.
   always begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = e.is_irq ? {31'd0, IRQ} : Dout;
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      @(posedge clk); #1;
      Addr = {27'd0, off};
      WE   = 1'b1;
      Din  = d;
      @(posedge clk); #1;
      WE   = 1'b0;
   endtask

   task automatic exp_irq(input logic v, input string nm);
      q.push_back('{name: nm, is_irq: 1'b1, val: {31'd0, v}});
   endtask

   task automatic exp_rd(input logic [2:0] off, input logic [31:0] v, input string nm);
      Addr = {27'd0, off};
      q.push_back('{name: nm, is_irq: 1'b0, val: v});
      @(negedge clk); #1;
   endtask

   initial begin
      #22 reset = 1'b1;
      #1;
      // Reset state
      exp_irq(1'b0, "rst_irq");
      exp_rd(IC_CTRL,  32'h0, "rst_ctrl");
      exp_rd(IC_MASK,  32'h0, "rst_mask");
      exp_rd(IC_MODE,  32'h0, "rst_mode");
      exp_rd(IC_PEND,  32'h0, "rst_pend");
      exp_rd(IC_CLAIM, 32'h0, "rst_claim");
      wr(3'd6, 32'hFFFF_FFFF);
      exp_rd(3'd6,    32'h0, "undef_rd");
      exp_rd(IC_CTRL, 32'h0, "undef_wr_ignored");

      // Level source, claim and complete
      wr(IC_MASK, 32'h7);
      wr(IC_MODE, 32'h0);
      wr(IC_CTRL, 32'h1);
      irq_src = 3'b010;
      tick(1);
      exp_irq(1'b0, "lvl_irq_k");
      exp_rd(IC_PEND, 32'h2, "lvl_pend_k");
      tick(1);
      exp_irq(1'b1, "lvl_irq_k1");
      exp_rd(IC_CLAIM, 32'h0000_0001, "lvl_claim_rd");
      wr(IC_CLAIM, 32'h0);
      exp_irq(1'b0, "lvl_irq_after_claim");
      exp_rd(IC_CLAIM, 32'h8000_0001, "lvl_claim_busy");
      wr(IC_COMPLETE, 32'h0);
      exp_irq(1'b0, "lvl_irq_at_complete");
      exp_rd(IC_CLAIM, 32'h0000_0001, "lvl_claim_idle");
      tick(1);
      exp_irq(1'b1, "lvl_irq_reassert");
      exp_rd(IC_PEND, 32'h2, "lvl_pend_still");
      irq_src = 3'b000;

      // Priority among edge sources
      wr(IC_MODE, 32'h7);
      irq_src = 3'b101;
      tick(1);
      irq_src = 3'b000;
      tick(3);
      exp_irq(1'b1, "pri_irq");
      exp_rd(IC_PEND,  32'h5, "pri_pend");
      exp_rd(IC_CLAIM, 32'h0, "pri_claim_id0");
      wr(IC_CLAIM, 32'h0);
      exp_rd(IC_CLAIM, 32'h8000_0000, "pri_busy0");
      exp_rd(IC_PEND,  32'h4, "pri_pend_after0");
      wr(IC_COMPLETE, 32'h0);
      exp_rd(IC_CLAIM, 32'h2, "pri_claim_id2");
      exp_rd(IC_PEND,  32'h4, "pri_pend_100");
      wr(IC_CLAIM, 32'h0);
      exp_rd(IC_PEND,  32'h0, "pri_pend_after2");
      exp_rd(IC_CLAIM, 32'h8000_0002, "pri_busy2");
      wr(IC_COMPLETE, 32'h0);
      tick(1);
      exp_irq(1'b0, "pri_irq_idle");
      exp_rd(IC_CLAIM, 32'h0, "pri_claim_none");

      // Edge arriving together with a W1C of the same bit
      @(posedge clk); #1;
      Addr    = {27'd0, IC_PEND};
      WE      = 1'b1;
      Din     = 32'h2;
      irq_src = 3'b010;
      @(posedge clk); #1;
      WE = 1'b0;
      exp_rd(IC_PEND, 32'h2, "w1c_set_wins");
      wr(IC_PEND, 32'h2);
      exp_rd(IC_PEND, 32'h0, "w1c_clear");
      tick(1);
      exp_irq(1'b0, "w1c_irq_low");
      exp_rd(IC_PEND, 32'h0, "w1c_pend_stays");
      irq_src = 3'b000;

      // Mask and global enable gating
      wr(IC_MASK, 32'h0);
      irq_src = 3'b001;
      tick(1);
      irq_src = 3'b000;
      tick(1);
      exp_irq(1'b0, "msk_irq_masked");
      exp_rd(IC_PEND, 32'h1, "msk_pend");
      wr(IC_CLAIM, 32'h0);
      exp_rd(IC_CLAIM, 32'h0, "msk_claim_ignored");
      exp_rd(IC_PEND,  32'h1, "msk_pend_kept");
      wr(IC_CTRL, 32'h0);
      wr(IC_MASK, 32'h1);
      wr(IC_CLAIM, 32'h0);
      exp_irq(1'b0, "ge_irq_off");
      exp_rd(IC_CLAIM, 32'h0, "ge_claim_ignored");
      exp_rd(IC_PEND,  32'h1, "ge_pend_kept");
      wr(IC_CTRL, 32'h1);
      exp_irq(1'b0, "ge_irq_not_yet");
      exp_rd(IC_CTRL, 32'h1, "ge_ctrl_rd");
      tick(1);
      exp_irq(1'b1, "ge_irq_on");
      exp_rd(IC_PEND, 32'h1, "ge_pend");
      wr(IC_MASK, 32'h0);
      tick(1);
      exp_irq(1'b0, "msk_irq_drop");
      exp_rd(IC_MASK, 32'h0, "msk_rd0");
      wr(IC_MASK, 32'h1);
      exp_irq(1'b0, "msk_irq_not_yet");
      exp_rd(IC_MASK, 32'h1, "msk_rd1");
      tick(1);
      exp_irq(1'b1, "msk_irq_on");
      exp_rd(IC_PEND, 32'h1, "msk_pend_on");
      wr(IC_CLAIM, 32'h0);
      wr(IC_COMPLETE, 32'h0);
      wr(IC_MASK, 32'h7);

      // Synchronized external source raised between edges
      @(negedge clk); #2;
      irq_src = 3'b100;
      tick(2);
      exp_irq(1'b0, "sync_irq_e2");
      exp_rd(IC_PEND, 32'h0, "sync_pend_e2");
      tick(1);
      exp_irq(1'b0, "sync_irq_e3");
      exp_rd(IC_PEND, 32'h4, "sync_pend_e3");
      tick(1);
      exp_irq(1'b1, "sync_irq_e4");
      exp_rd(IC_CLAIM, 32'h2, "sync_claim_id");
      wr(IC_CLAIM, 32'h0);
      wr(IC_COMPLETE, 32'h0);

      // Asynchronous reset while in service
      irq_src = 3'b110;
      tick(2);
      wr(IC_CLAIM, 32'h0);
      exp_rd(IC_CLAIM, 32'h8000_0001, "rsv_busy1");
      Addr    = {27'd0, IC_MASK};
      irq_src = 3'b000;
      reset   = 1'b0;
      #1;
      exp_irq(1'b0, "rsv_irq_now");
      q.push_back('{name: "rsv_mask_now", is_irq: 1'b0, val: 32'h0});
      -> chk_ev;
      #1;
      reset = 1'b1;
      exp_rd(IC_CLAIM, 32'h0, "rsv_claim_after");
      exp_irq(1'b0, "rsv_irq_after");
      exp_rd(IC_CTRL, 32'h0, "rsv_ctrl_after");

      @(negedge clk); #1;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
